// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the producer handshakes and the broadcast bus of cdb_arbiter.
//   rs_valid/rs_ready/rs_rob_id/rs_data     : result offered by the RS ALU path
//   lsb_valid/lsb_ready/lsb_rob_id/lsb_data : result offered by the load/store buffer
//   cdb_valid/cdb_rob_id/cdb_data/cdb_src   : registered common-data-bus broadcast
// Modports:
//   master : producers and CDB snoopers (drive offers, observe ready and CDB)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int ROB_W = 4
);
  logic             rs_valid;
  logic             rs_ready;
  logic [ROB_W-1:0] rs_rob_id;
  logic [31:0]      rs_data;

  logic             lsb_valid;
  logic             lsb_ready;
  logic [ROB_W-1:0] lsb_rob_id;
  logic [31:0]      lsb_data;

  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_data;
  logic             cdb_src;

  modport master (
    output rs_valid, rs_rob_id, rs_data,
    output lsb_valid, lsb_rob_id, lsb_data,
    input  rs_ready, lsb_ready,
    input  cdb_valid, cdb_rob_id, cdb_data, cdb_src
  );

  modport slave (
    input  rs_valid, rs_rob_id, rs_data,
    input  lsb_valid, lsb_rob_id, lsb_data,
    output rs_ready, lsb_ready,
    output cdb_valid, cdb_rob_id, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus arbiter. Results from the RS ALU path and the load/store
// buffer are queued in one small FIFO per source; each cycle one queued result
// is granted (round-robin on ties) onto a registered broadcast bus snooped by
// the ROB, RS and LSB. A mispredict flush empties both FIFOs.
// Ports:
//   clk_in : clock, all state on the rising edge
//   rst_in : synchronous active-high reset (priority over flush and rdy_in)
//   rdy_in : global enable; low freezes all state except flush
//   flush  : mispredict flush, empties both FIFOs and drops cdb_valid
//   bus    : cdb_arbiter_if.slave (source handshakes + CDB outputs)
// Optional feature:
//   CDB_BYPASS_EN : when defined, a result arriving at an empty FIFO may go
//                   straight onto the CDB in the same edge (1-edge latency).
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush,
  cdb_arbiter_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage and bookkeeping, one set per source
  logic [ROB_W-1:0] rs_id_mem_r   [FIFO_DEPTH];
  logic [31:0]      rs_data_mem_r [FIFO_DEPTH];
  logic [ROB_W-1:0] lsb_id_mem_r  [FIFO_DEPTH];
  logic [31:0]      lsb_data_mem_r[FIFO_DEPTH];
  logic [PW-1:0]    rs_head_r, rs_tail_r, lsb_head_r, lsb_tail_r;
  logic [CW-1:0]    rs_cnt_r, lsb_cnt_r;

  // 0 = RS, 1 = LSB; reset to LSB so RS wins the first tie
  logic             last_grant_r;

  logic             cdb_valid_r;
  logic [ROB_W-1:0] cdb_rob_id_r;
  logic [31:0]      cdb_data_r;
  logic             cdb_src_r;

  logic             active_s;
  logic             rs_ready_s, lsb_ready_s;
  logic             rs_push_s, lsb_push_s;
  logic             rs_nonempty_s, lsb_nonempty_s;
  logic             rs_byp_s, lsb_byp_s;
  logic             rs_cand_s, lsb_cand_s;
  logic             grant_rs_s, grant_lsb_s;
  logic             rs_pop_s, lsb_pop_s;
  logic             rs_wr_s, lsb_wr_s;
  logic [ROB_W-1:0] win_id_s;
  logic [31:0]      win_data_s;

  // Next FIFO occupancy: a simultaneous write and pop cancel out
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic wr, input logic pop);
    logic [CW-1:0] res;
    case ({wr, pop})
      2'b10:   res = cnt + CW'(1'b1);
      2'b01:   res = cnt - CW'(1'b1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  // Readiness, candidate selection, round-robin grant and winner data mux
  always_comb begin
    active_s       = rdy_in & ~flush;
    // Readiness looks only at registered occupancy, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    rs_ready_s     = active_s & (rs_cnt_r < CW'(FIFO_DEPTH));
    lsb_ready_s    = active_s & (lsb_cnt_r < CW'(FIFO_DEPTH));
    rs_push_s      = bus.rs_valid & rs_ready_s;
    lsb_push_s     = bus.lsb_valid & lsb_ready_s;
    rs_nonempty_s  = (rs_cnt_r != {CW{1'b0}});
    lsb_nonempty_s = (lsb_cnt_r != {CW{1'b0}});
`ifdef CDB_BYPASS_EN
    rs_byp_s       = ~rs_nonempty_s & rs_push_s;
    lsb_byp_s      = ~lsb_nonempty_s & lsb_push_s;
`else
    rs_byp_s       = 1'b0;
    lsb_byp_s      = 1'b0;
`endif
    rs_cand_s      = rs_nonempty_s | rs_byp_s;
    lsb_cand_s     = lsb_nonempty_s | lsb_byp_s;
    // On a tie the source that did not win last time gets the bus.
    grant_rs_s     = rs_cand_s & (~lsb_cand_s | last_grant_r);
    grant_lsb_s    = lsb_cand_s & ~grant_rs_s;
    rs_pop_s       = active_s & grant_rs_s & rs_nonempty_s;
    lsb_pop_s      = active_s & grant_lsb_s & lsb_nonempty_s;
    // A bypassed winner goes straight to the CDB and is never stored.
    rs_wr_s        = rs_push_s & ~(grant_rs_s & rs_byp_s);
    lsb_wr_s       = lsb_push_s & ~(grant_lsb_s & lsb_byp_s);

    win_id_s       = {ROB_W{1'b0}};
    win_data_s     = 32'h0000_0000;
    if (grant_rs_s) begin
      if (rs_nonempty_s) begin
        win_id_s   = rs_id_mem_r[rs_head_r];
        win_data_s = rs_data_mem_r[rs_head_r];
      end else begin
        win_id_s   = bus.rs_rob_id;
        win_data_s = bus.rs_data;
      end
    end else if (grant_lsb_s) begin
      if (lsb_nonempty_s) begin
        win_id_s   = lsb_id_mem_r[lsb_head_r];
        win_data_s = lsb_data_mem_r[lsb_head_r];
      end else begin
        win_id_s   = bus.lsb_rob_id;
        win_data_s = bus.lsb_data;
      end
    end else begin
      win_id_s   = {ROB_W{1'b0}};
      win_data_s = 32'h0000_0000;
    end
  end

  // FIFO state, round-robin pointer and registered CDB outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rs_id_mem_r[i]    <= {ROB_W{1'b0}};
        rs_data_mem_r[i]  <= 32'h0000_0000;
        lsb_id_mem_r[i]   <= {ROB_W{1'b0}};
        lsb_data_mem_r[i] <= 32'h0000_0000;
      end
      rs_head_r    <= {PW{1'b0}};
      rs_tail_r    <= {PW{1'b0}};
      lsb_head_r   <= {PW{1'b0}};
      lsb_tail_r   <= {PW{1'b0}};
      rs_cnt_r     <= {CW{1'b0}};
      lsb_cnt_r    <= {CW{1'b0}};
      last_grant_r <= 1'b1;
      cdb_valid_r  <= 1'b0;
      cdb_rob_id_r <= {ROB_W{1'b0}};
      cdb_data_r   <= 32'h0000_0000;
      cdb_src_r    <= 1'b0;
    end else if (flush) begin
      rs_head_r   <= {PW{1'b0}};
      rs_tail_r   <= {PW{1'b0}};
      lsb_head_r  <= {PW{1'b0}};
      lsb_tail_r  <= {PW{1'b0}};
      rs_cnt_r    <= {CW{1'b0}};
      lsb_cnt_r   <= {CW{1'b0}};
      cdb_valid_r <= 1'b0;
    end else if (rdy_in) begin
      if (rs_wr_s) begin
        rs_id_mem_r[rs_tail_r]   <= bus.rs_rob_id;
        rs_data_mem_r[rs_tail_r] <= bus.rs_data;
        rs_tail_r                <= rs_tail_r + PW'(1'b1);
      end
      if (rs_pop_s) begin
        rs_head_r <= rs_head_r + PW'(1'b1);
      end
      rs_cnt_r <= next_count(rs_cnt_r, rs_wr_s, rs_pop_s);

      if (lsb_wr_s) begin
        lsb_id_mem_r[lsb_tail_r]   <= bus.lsb_rob_id;
        lsb_data_mem_r[lsb_tail_r] <= bus.lsb_data;
        lsb_tail_r                 <= lsb_tail_r + PW'(1'b1);
      end
      if (lsb_pop_s) begin
        lsb_head_r <= lsb_head_r + PW'(1'b1);
      end
      lsb_cnt_r <= next_count(lsb_cnt_r, lsb_wr_s, lsb_pop_s);

      if (grant_rs_s | grant_lsb_s) begin
        cdb_valid_r  <= 1'b1;
        cdb_rob_id_r <= win_id_s;
        cdb_data_r   <= win_data_s;
        cdb_src_r    <= grant_lsb_s;
        last_grant_r <= grant_lsb_s;
      end else begin
        // Idle bus: only the valid flag drops, payload registers hold.
        cdb_valid_r <= 1'b0;
      end
    end else begin
      cdb_valid_r <= cdb_valid_r;
    end
  end

  assign bus.rs_ready   = rs_ready_s;
  assign bus.lsb_ready  = lsb_ready_s;
  assign bus.cdb_valid  = cdb_valid_r;
  assign bus.cdb_rob_id = cdb_rob_id_r;
  assign bus.cdb_data   = cdb_data_r;
  assign bus.cdb_src    = cdb_src_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Drives cdb_arbiter with directed scenarios followed by random traffic and
// compares every cycle against a queue-based model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int ROB_W = 4;
  localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rdy, flush;

  cdb_arbiter_if #(.ROB_W(ROB_W)) bus ();

  cdb_arbiter #(.ROB_W(ROB_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROB_W-1:0] id;
    logic [31:0]      data;
  } ent_t;

  // Model state
  ent_t             rs_q[$];
  ent_t             lsb_q[$];
  bit               m_last;
  bit               m_valid;
  logic [ROB_W-1:0] m_id;
  logic [31:0]      m_data;
  bit               m_src;
  bit               m_init = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check readies, advance model, check CDB.
  task automatic step(input bit r, input bit f, input bit rd,
                      input bit rv, input logic [ROB_W-1:0] rid, input logic [31:0] rdat,
                      input bit lv, input logic [ROB_W-1:0] lid, input logic [31:0] ldat);
    bit   rs_rdy, lsb_rdy, rp, lp, rc, lc;
    ent_t e;
    rst = r; flush = f; rdy = rd;
    bus.rs_valid = rv;  bus.rs_rob_id = rid;  bus.rs_data = rdat;
    bus.lsb_valid = lv; bus.lsb_rob_id = lid; bus.lsb_data = ldat;
    #1;
    rs_rdy  = rd && !f && (rs_q.size() < DEPTH);
    lsb_rdy = rd && !f && (lsb_q.size() < DEPTH);
    if (m_init) begin
      check_val("rs_ready",  64'(bus.rs_ready),  64'(rs_rdy));
      check_val("lsb_ready", 64'(bus.lsb_ready), 64'(lsb_rdy));
    end
    if (r) begin
      rs_q.delete(); lsb_q.delete();
      m_valid = 0; m_id = '0; m_data = '0; m_src = 0; m_last = 1;
      m_init = 1'b1;
    end else if (f) begin
      rs_q.delete(); lsb_q.delete();
      m_valid = 0;
    end else if (rd) begin
      rp = rv && rs_rdy;
      lp = lv && lsb_rdy;
      rc = (rs_q.size() > 0) || (BYP && rp);
      lc = (lsb_q.size() > 0) || (BYP && lp);
      if (rc && (!lc || m_last)) begin
        if (rs_q.size() > 0) begin
          e = rs_q.pop_front();
          if (rp) rs_q.push_back('{rid, rdat});
        end else begin
          e = '{rid, rdat};
        end
        if (lp) lsb_q.push_back('{lid, ldat});
        m_valid = 1; m_id = e.id; m_data = e.data; m_src = 0; m_last = 0;
      end else if (lc) begin
        if (lsb_q.size() > 0) begin
          e = lsb_q.pop_front();
          if (lp) lsb_q.push_back('{lid, ldat});
        end else begin
          e = '{lid, ldat};
        end
        if (rp) rs_q.push_back('{rid, rdat});
        m_valid = 1; m_id = e.id; m_data = e.data; m_src = 1; m_last = 1;
      end else begin
        if (rp) rs_q.push_back('{rid, rdat});
        if (lp) lsb_q.push_back('{lid, ldat});
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check_val("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    check_val("cdb_rob_id", 64'(bus.cdb_rob_id), 64'(m_id));
    check_val("cdb_data", 64'(bus.cdb_data), 64'(m_data));
    check_val("cdb_src", 64'(bus.cdb_src), 64'(m_src));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0, '0, 32'h0, 0, '0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rdy = 1'b1;
    bus.rs_valid = 1'b0; bus.rs_rob_id = '0; bus.rs_data = 32'h0;
    bus.lsb_valid = 1'b0; bus.lsb_rob_id = '0; bus.lsb_data = 32'h0;
    @(negedge clk);

    // Reset and a single RS result
    step(1, 0, 1, 0, '0, 32'h0, 0, '0, 32'h0);
    step(1, 0, 1, 0, '0, 32'h0, 0, '0, 32'h0);
    step(0, 0, 1, 1, 4'd3, 32'hDEAD_BEEF, 0, '0, 32'h0);
    idle(3);

    // Contention: both sources push for 6 cycles
    for (int i = 0; i < 6; i++)
      step(0, 0, 1, 1, 4'(i), $urandom, 1, 4'(8 + i), $urandom);
    idle(8);

    // Backpressure: LSB pushes continuously while RS trickles in
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, (i % 2) == 0, 4'(i), $urandom, 1, 4'(i + 4), $urandom);
    idle(8);

    // Flush with entries queued, then a fresh push
    step(0, 0, 1, 1, 4'd1, 32'h1111_0001, 1, 4'd9, 32'h9999_0001);
    step(0, 0, 1, 1, 4'd2, 32'h1111_0002, 0, '0, 32'h0);
    step(0, 0, 1, 1, 4'd4, 32'h1111_0004, 1, 4'd10, 32'h9999_0002);
    step(0, 1, 1, 1, 4'd5, 32'h1111_0005, 1, 4'd11, 32'h9999_0003);
    step(0, 0, 1, 1, 4'd6, 32'h2222_0006, 0, '0, 32'h0);
    idle(4);

    // rdy_in stall with queued entries
    step(0, 0, 1, 1, 4'd1, $urandom, 1, 4'd2, $urandom);
    step(0, 0, 1, 1, 4'd3, $urandom, 1, 4'd4, $urandom);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 4'd7, $urandom, 1, 4'd7, $urandom);
    idle(6);

    // Mid-operation reset with both FIFOs full
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 1, 4'(i), $urandom, 1, 4'(8 + i), $urandom);
    step(1, 0, 1, 1, 4'd5, $urandom, 1, 4'd6, $urandom);
    step(0, 0, 1, 1, 4'd12, $urandom, 1, 4'd13, $urandom);
    idle(4);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0, 4'($urandom), $urandom,
           $urandom_range(0, 2) != 0, 4'($urandom), $urandom);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the execution side and the reorder buffer. Collects completed results from the reservation-station ALU path and the load/store buffer, queues each in a small per-source FIFO, and grants one result per cycle onto a single registered broadcast bus. The ROB, RS and LSB all snoop this bus. Fairness comes from round-robin arbitration, and a branch-mispredict flush discards every queued result.

## Interface
Parameters:
- ROB_W, 4, width of ROB index (matches `ROB_WIDTH)
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥2

Ports:
- clk_in  in  1  clock, all state on rising edge
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low freezes all state except flush
- flush  in  1  mispredict flush from ROB
- rs_valid  in  1  RS result offered
- rs_ready  out  1  RS FIFO can accept
- rs_rob_id  in  ROB_W  destination ROB entry of RS result
- rs_data  in  32  RS result value
- lsb_valid  in  1  LSB result offered
- lsb_ready  out  1  LSB FIFO can accept
- lsb_rob_id  in  ROB_W  destination ROB entry of LSB result
- lsb_data  in  32  LSB result value
- cdb_valid  out  1  broadcast valid, registered
- cdb_rob_id  out  ROB_W  broadcast ROB index, registered
- cdb_data  out  32  broadcast value, registered
- cdb_src  out  1  winning source: 0 = RS, 1 = LSB, registered

## Operation
- Each source has a FIFO of FIFO_DEPTH entries {rob_id, data}, with head/tail pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Readiness: x_ready = rdy_in & ~flush & (count_x < FIFO_DEPTH). It depends only on registered count, never on x_valid or same-cycle pops, so a full FIFO is not ready even when popping that cycle.
- Transfer: x_valid & x_ready at a rising edge pushes one entry. Data presented while not ready is ignored; the source must hold it.
- Arbitration runs each edge with rdy_in=1 and flush=0. A source is a candidate when its FIFO is non-empty.
  - One candidate: that source wins.
  - Two candidates: the source not equal to last_grant wins.
  - The winner's head is popped into the cdb_* registers and cdb_valid is set to 1. last_grant takes the winner's id.
  - No candidate: cdb_valid is set to 0. The cdb_rob_id, cdb_data and cdb_src registers keep their values.
- A push and a pop on the same FIFO in the same edge leaves count unchanged.
- Flush, at an edge with flush=1, regardless of rdy_in:
  - both FIFOs are emptied (pointers and counts go to 0);
  - cdb_valid is set to 0;
  - last_grant is unchanged;
  - no push occurs.
- rdy_in=0 with flush=0: nothing changes, readies are low, and cdb_valid holds its registered value.
- Reset values: cdb_valid=0, cdb_rob_id=0, cdb_data=0, cdb_src=0, all pointers and counts 0, last_grant=1 (LSB), so RS wins the first tie. rs_ready and lsb_ready are 1 after reset whenever rdy_in=1 and flush=0.
- rst_in has priority over flush and rdy_in.

## Timing
- Default latency is 2 edges. A push at edge N makes the entry visible on the CDB after edge N+1 at the earliest, if it wins.
- Throughput is one broadcast per cycle total. Each source sustains one push per cycle while the other is idle.
- cdb_valid is a single-cycle pulse per result. Consumers sample it every cycle and there is no backpressure from the CDB.
- Worst-case wait for a non-empty source under contention is 1 cycle, from strict alternation.
- A reset mid-operation discards every queued and in-flight result at that edge.

## Configuration
- CDB_BYPASS_EN defined:
  - a source whose FIFO is empty and whose x_valid & x_ready is high at edge N becomes a candidate with the incoming value;
  - if that source wins, the value goes straight into the cdb_* registers at edge N and is not pushed, giving 1-edge latency;
  - if it loses, the value is pushed normally.
  - Arbitration rules are otherwise unchanged.
- CDB_BYPASS_EN undefined: every result goes through the FIFO, giving a fixed 2-edge minimum latency.

## Test plan
- Reset, single result: reset, then RS offers rob_id=3, data=0xDEADBEEF for one cycle -> cdb_valid=1 with {3, 0xDEADBEEF, src=0} exactly 2 edges after the push (1 edge with CDB_BYPASS_EN); cdb_valid=0 the cycle after.
- Contention: both sources push every cycle for 6 cycles, RS ids 0..5 and LSB ids 8..13 -> CDB order RS0, LSB8, RS1, LSB9, ... alternating; each source's ids appear in order, none lost or duplicated.
- Full/backpressure: hold LSB pushing while RS keeps its FIFO non-empty, FIFO_DEPTH=2 -> lsb_ready drops to 0 when count=2 and ignored data is never broadcast; ready returns after an LSB grant.
- Flush: queue 2 RS and 1 LSB entries, assert flush for one cycle -> rs_ready=lsb_ready=0 during flush; cdb_valid=0 next cycle; no queued entry is ever broadcast; a new push after flush broadcasts normally.
- rdy_in stall: with entries queued, drop rdy_in for 3 cycles -> cdb outputs and counts frozen, readies 0; broadcasting resumes in the same order on re-assertion.
- Mid-operation reset: pulse rst_in with both FIFOs full -> all outputs return to reset values next cycle; the first tie afterwards is granted to RS.
